// File: rtl/uart_rx_if.sv
// uart_rx_if -- signal bundle between the UART receiver and its consumer.
//   rx            serial line into the receiver (idle high, asynchronous)
//   data          received byte
//   data_valid    one-cycle strobe: data holds a new good byte
//   frame_err     one-cycle strobe: stop bit sampled low
//   uart_rx_busy  receiver is inside a frame
//   rd_en         consumer pops the held byte        (UART_RX_HOLD_EN only)
//   rx_ready      held byte not yet read             (UART_RX_HOLD_EN only)
//   overrun       sticky: byte landed on unread byte (UART_RX_HOLD_EN only)
// Modports: master = receiver side, slave = consumer / line driver side.
// Optional feature macro: UART_RX_HOLD_EN.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       uart_rx_busy;
`ifdef UART_RX_HOLD_EN
  logic       rd_en;
  logic       rx_ready;
  logic       overrun;

  modport master (
    input  rx, rd_en,
    output data, data_valid, frame_err, uart_rx_busy, rx_ready, overrun
  );
  modport slave (
    output rx, rd_en,
    input  data, data_valid, frame_err, uart_rx_busy, rx_ready, overrun
  );
`else
  modport master (
    input  rx,
    output data, data_valid, frame_err, uart_rx_busy
  );
  modport slave (
    output rx,
    input  data, data_valid, frame_err, uart_rx_busy
  );
`endif
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver, LSB first.
//   The asynchronous rx pin is brought in through a two-flop synchroniser;
//   the start bit is re-checked at mid-bit, then every data bit and the stop
//   bit are sampled at their centres. A good frame updates data and pulses
//   data_valid; a low stop bit pulses frame_err and waits for the line to
//   return high before looking for a new start bit.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous reset, active low
//   bus    uart_rx_if.master (rx in; data, data_valid, frame_err,
//          uart_rx_busy out; rd_en in / rx_ready, overrun out when the
//          holding register is built)
// Optional feature macro: UART_RX_HOLD_EN (1-entry holding register with
//   rx_ready / overrun flags and an rd_en pop).
module uart_rx #(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 9600
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.master bus
);

  localparam int BIT_CNT_MAX  = (CLK_FREQ / BAUD) - 1;
  localparam int HALF_CNT_MAX = (CLK_FREQ / BAUD) / 2 - 1;
  localparam int CNT_W        = $clog2(BIT_CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT_MAX);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT_MAX);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e           state_q;
  logic             rx_meta_q;
  logic             rx_s_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             data_valid_q;
  logic             frame_err_q;
  logic             busy_q;
`ifdef UART_RX_HOLD_EN
  logic             rx_ready_q;
  logic             overrun_q;
`endif

  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never looks like a start edge.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM with registered strobes. Strobes default low each cycle so
  // they last exactly one clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_HOLD_EN
      rx_ready_q   <= 1'b0;
      overrun_q    <= 1'b0;
`endif
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_HOLD_EN
      // A pop clears the flag; a byte completing this same cycle overrides
      // it below and keeps rx_ready set.
      if (bus.rd_en && rx_ready_q) begin
        rx_ready_q <= 1'b0;
      end
`endif

      unique case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q    <= START;
            baud_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt_q == HALF_LAST) begin
            if (rx_s_q) begin
              // Line went back high before mid-bit: a glitch, not a start.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= DATA;
              baud_cnt_q <= '0;
              bit_cnt_q  <= '0;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt_q == BIT_LAST) begin
            // LSB arrives first, so each new bit enters at the top and the
            // byte is aligned after the eighth shift.
            shift_q    <= {rx_s_q, shift_q[7:1]};
            baud_cnt_q <= '0;
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= STOP;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt_q == BIT_LAST) begin
            baud_cnt_q <= '0;
            busy_q     <= 1'b0;
            if (rx_s_q) begin
              state_q      <= IDLE;
              data_q       <= shift_q;
              data_valid_q <= 1'b1;
`ifdef UART_RX_HOLD_EN
              if (rx_ready_q && !bus.rd_en) begin
                overrun_q <= 1'b1;
              end
              rx_ready_q <= 1'b1;
`endif
            end else begin
              // Stop bit low (framing error or break): keep the old byte and
              // ignore the line until it idles high again.
              state_q     <= WAIT_HIGH;
              frame_err_q <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (rx_s_q) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data         = data_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.uart_rx_busy = busy_q;
`ifdef UART_RX_HOLD_EN
  assign bus.rx_ready     = rx_ready_q;
  assign bus.overrun      = overrun_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx.
//   A behavioural model predicts, for every frame put on the line, whether a
//   data_valid or frame_err strobe must appear, with which byte, and at what
//   cycle (start-bit drive time + 2 sync cycles + 9.5 bit times + 1 clock).
//   One compare process checks the DUT against that prediction every cycle.
//   Directed frames pin the model with literal byte values; a randomized
//   mix of good frames, bad stop bits, glitches and gaps follows.
module tb_uart_rx;

  localparam int CLK_FREQ = 10_000_000;
  localparam int BAUD     = 625_000;
  localparam int BIT      = CLK_FREQ / BAUD;          // clocks per bit
  localparam int HALF     = BIT / 2;
  localparam int LAT      = 2 + (19 * BIT) / 2 + 1;   // start drive -> strobe
  localparam int GLITCH   = (BIT * 300) / 1041;       // ~0.29 bit times

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int     errors = 0;
  int     checks = 0;
  longint cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] val;
    longint     due;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_data = 8'h00;
  bit         checking   = 1'b0;
`ifdef UART_RX_HOLD_EN
  bit         m_ready   = 1'b0;
  bit         m_overrun = 1'b0;
  bit         rd_prev   = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 25)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one 8N1 frame. stop_low > 0 holds the stop bit (and beyond) low
  // for that many bit times before releasing the line.
  task automatic send_frame(input logic [7:0] v, input int stop_low);
    exp_t e;
    e.is_err = (stop_low > 0);
    e.val    = v;
    e.due    = cyc + LAT;
    exp_q.push_back(e);
    bus.rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      bus.rx = v[i];
      tick(BIT);
    end
    if (stop_low > 0) begin
      bus.rx = 1'b0;
      tick(stop_low * BIT);
      bus.rx = 1'b1;
    end else begin
      bus.rx = 1'b1;
      tick(BIT);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  32'(bus.data),         32'h00);
    check({tag, "_valid"}, 32'(bus.data_valid),   32'h0);
    check({tag, "_ferr"},  32'(bus.frame_err),    32'h0);
    check({tag, "_busy"},  32'(bus.uart_rx_busy), 32'h0);
`ifdef UART_RX_HOLD_EN
    check({tag, "_ready"},   32'(bus.rx_ready), 32'h0);
    check({tag, "_overrun"}, 32'(bus.overrun),  32'h0);
`endif
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_data = 8'h00;
`ifdef UART_RX_HOLD_EN
    m_ready   = 1'b0;
    m_overrun = 1'b0;
    rd_prev   = 1'b0;
`endif
  endtask

  // Compare process: outputs sampled on the falling edge, half a clock away
  // from the edge that updates them.
  always @(negedge clk) begin
    exp_t   e;
    longint off;
    if (checking) begin
      if (bus.data_valid || bus.frame_err) begin
        check("strobe_exclusive", 32'(bus.data_valid & bus.frame_err), 32'h0);
        check("busy_at_strobe", 32'(bus.uart_rx_busy), 32'h0);
        check("strobe_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("strobe_kind_ferr", 32'(bus.frame_err), 32'(e.is_err));
          off = cyc - e.due;
          check("strobe_cycle_offset", (off >= -1 && off <= 1) ? 32'h0 : 32'(off), 32'h0);
          if (!e.is_err) model_data = e.val;
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due + 1) begin
        check("strobe_missing", 32'(bus.data_valid | bus.frame_err), 32'h1);
        void'(exp_q.pop_front());
      end
      check("data_value", 32'(bus.data), 32'(model_data));
`ifdef UART_RX_HOLD_EN
      if (bus.data_valid) begin
        if (m_ready && !rd_prev) m_overrun = 1'b1;
        m_ready = 1'b1;
      end else if (rd_prev && m_ready) begin
        m_ready = 1'b0;
      end
      check("rx_ready", 32'(bus.rx_ready), 32'(m_ready));
      check("overrun",  32'(bus.overrun),  32'(m_overrun));
      rd_prev = bus.rd_en;
`endif
    end
  end

  // Hard stop in case the stimulus itself ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int         r;
    bus.rx = 1'b1;
`ifdef UART_RX_HOLD_EN
    bus.rd_en = 1'b0;
`endif
    rst_n = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();
    checking = 1'b1;
    tick(BIT);

    // Single frame 0x55.
    send_frame(8'h55, 0);
    tick(2);
    check("frame_55_data", 32'(bus.data), 32'h55);
    check("frame_55_idle", 32'(bus.uart_rx_busy), 32'h0);

    // Back-to-back 0xA3, 0x0F with zero idle gap.
    send_frame(8'hA3, 0);
    send_frame(8'h0F, 0);
    tick(2);
    check("b2b_last_data", 32'(bus.data), 32'h0F);
    check("b2b_drained", 32'(exp_q.size()), 32'h0);

    // Short low glitch: receiver leaves IDLE, then returns without a strobe.
    bus.rx = 1'b0;
    tick(GLITCH);
    bus.rx = 1'b1;
    tick(3);
    check("glitch_busy_high", 32'(bus.uart_rx_busy), 32'h1);
    tick(BIT);
    check("glitch_busy_low", 32'(bus.uart_rx_busy), 32'h0);
    check("glitch_data_kept", 32'(bus.data), 32'h0F);

    // 0xC4 with stop bit held low for 3 bit times, then a good 0x31.
    send_frame(8'hC4, 3);
    tick(2);
    check("ferr_data_kept", 32'(bus.data), 32'h0F);
    check("ferr_busy_low", 32'(bus.uart_rx_busy), 32'h0);
    tick(BIT);
    send_frame(8'h31, 0);
    tick(2);
    check("after_ferr_data", 32'(bus.data), 32'h31);

    // 0x7E aborted by a one-clock reset in the middle of data bit 4.
    v = 8'h7E;
    bus.rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 4; i++) begin
      bus.rx = v[i];
      tick(BIT);
    end
    bus.rx = v[4];
    tick(HALF);
    check("busy_mid_frame", 32'(bus.uart_rx_busy), 32'h1);
    checking = 1'b0;
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("midframe_reset");
    rst_n = 1'b1;
    bus.rx = 1'b1;
    model_reset();
    checking = 1'b1;
    tick(2 * BIT);
    send_frame(8'h12, 0);
    tick(2);
    check("after_reset_data", 32'(bus.data), 32'h12);

`ifdef UART_RX_HOLD_EN
    // Two bytes without a pop: overwrite plus sticky overrun, then pop.
    send_frame(8'h11, 0);
    send_frame(8'h22, 0);
    tick(2);
    check("hold_ready_set", 32'(bus.rx_ready), 32'h1);
    check("hold_data", 32'(bus.data), 32'h22);
    check("hold_overrun", 32'(bus.overrun), 32'h1);
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    check("hold_ready_cleared", 32'(bus.rx_ready), 32'h0);
    tick(BIT);
`endif

    // Randomized mix of traffic.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        bus.rx = 1'b0;
        tick($urandom_range(1, HALF - 2));
        bus.rx = 1'b1;
        tick(BIT);
      end else if (r == 1) begin
        send_frame(8'($urandom), $urandom_range(1, 2));
        tick($urandom_range(3, BIT));
      end else begin
        send_frame(8'($urandom), 0);
        tick($urandom_range(0, BIT));
      end
    end

    tick(LAT);
    check("final_drained", 32'(exp_q.size()), 32'h0);
    check("final_busy_low", 32'(bus.uart_rx_busy), 32'h0);
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
